nco_sweep_ctrl: RTL and testbench
=================================

# nco_sweep_ctrl

Sequencer for the quadrature NCO. It generates the NCO's `clk_en` sample strobe from a programmable prescaler and drives its 8-bit `phase_increment`. The increment is stepped through a start/stop/step frequency sweep, with a programmable dwell per step. It sits between the host/config logic and the NCO, replacing the static increment and enable tie-offs.

## Interface
- `PRESCALE_W`, default 8: width of the sample-rate prescaler.
- `DWELL_W`, default 8: width of the per-step dwell count.

- `clock`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse; launches a sweep when idle.
- `abort`  in  1  one-cycle pulse; terminates a sweep.
- `mode`  in  2  sweep mode: 00 single, 01 repeat, 10 triangle, 11 treated as single.
- `prescale`  in  PRESCALE_W  `clk_en` period = `prescale`+1 clocks.
- `f_start`, `f_stop`, `f_step`  in  8 each  sweep bounds and step size; `f_step`=0 is treated as 1.
- `dwell`  in  DWELL_W  samples per step = `dwell`+1.
- `clk_en`  out  1  registered NCO sample strobe.
- `phase_increment`  out  8  registered NCO increment.
- `busy`  out  1  high while sweeping.
- `done`  out  1  one-cycle pulse at the end of a single sweep.
- `step_strobe`  out  1  one-cycle pulse on every cycle `phase_increment` is loaded.

## Operation
- **Prescaler** (free-running in all states):
  - Down-counter reloads `prescale` on reaching 0.
  - `clk_en`=1 in the cycle after the counter reads 0.
  - `prescale`=0 gives `clk_en` constantly 1 after the first post-reset cycle.
  - `prescale` is sampled live at each reload.
- **Config latch:** `mode`, `f_start`, `f_stop`, `f_step` and `dwell` are latched on an accepted `start`. Changes during a sweep have no effect.
- **States:** IDLE, UP, DOWN, DONE.
  - **IDLE.**
    - `start` (with `abort` low) → UP.
    - On that transition: `phase_increment`←`f_start`, dwell counter←`dwell`, `step_strobe`=1.
    - `phase_increment` otherwise holds its last value.
  - **UP / DOWN.** Act only on `clk_en` cycles:
    - If the dwell counter ≠ 0, decrement it.
    - Otherwise perform a step and reload the dwell counter.
  - **Up step.**
    - Form the 9-bit sum `phase_increment`+`f_step`.
    - If the sum ≤ `f_stop`: load it and pulse `step_strobe`.
    - Otherwise the top endpoint is reached:
      - single → DONE;
      - repeat → load `f_start`, pulse `step_strobe`, stay in UP;
      - triangle → DOWN, increment unchanged, so the endpoint is held for a second dwell.
  - **Down step** (triangle only).
    - Form the 9-bit difference `phase_increment`−`f_step`.
    - If there is no borrow and the result ≥ `f_start`: load it and pulse `step_strobe`.
    - Otherwise → UP, increment unchanged.
  - **DONE.** Lasts one cycle: `done`=1, `busy`=0, then → IDLE.
- **Degenerate bounds:** if `f_start` ≥ `f_stop`, the first up step hits the endpoint.
  - single: one dwell at `f_start`, then DONE.
  - repeat: reloads `f_start` every dwell.
  - triangle: alternates UP/DOWN at `f_start`.
- **Non-aligned bounds:** the sweep never exceeds `f_stop`. The top value is the largest `f_start`+k·`f_step` ≤ `f_stop`.
- **Abort:**
  - `abort` in any non-IDLE state → IDLE next cycle.
  - No `done` pulse; `phase_increment` holds.
- **Simultaneous events:**
  - `start`+`abort` in the same cycle: `abort` wins and the start is dropped.
  - `start` while busy or in DONE is ignored.
- **Reset:**
  - All outputs 0; state IDLE; prescaler and dwell counters 0.
  - Reset mid-sweep behaves identically to power-up.

## Timing
- `start` sampled at cycle t → at t+1: `busy`=1, `phase_increment`=`f_start`, `step_strobe`=1.
- A step decision on a `clk_en` cycle at t produces the new `phase_increment` and `step_strobe` at t+1.
- Each increment value is present for exactly (`dwell`+1) `clk_en` pulses.
  - Exception: triangle endpoints, which are present for 2×(`dwell`+1) pulses.
- `done` asserts one cycle after the final `clk_en` of a single sweep. `busy` falls in the same cycle.
- All outputs are registered; there is no combinational input-to-output path.

## Structure
- Shared package `nco_ctrl_pkg` holds:
  - the state encoding (IDLE/UP/DOWN/DONE);
  - mode constants (`MODE_SINGLE`, `MODE_REPEAT`, `MODE_TRIANGLE`);
  - the NCO increment width (8).
- Sub-module `nco_prescaler` generates `clk_en` (`clock`, `reset_n`, `prescale`). It is reusable by other sample-rate consumers.
- The top module contains the FSM, config latch, dwell counter and increment arithmetic.

## Test plan
- **Reset mid-sweep.** Assert `reset_n`=0 asynchronously between clock edges → all outputs 0 immediately; IDLE after release.
- **Prescaler period.** `prescale`=3 → `clk_en` high exactly 1 of every 4 clocks. `prescale`=0 → `clk_en` constantly 1.
- **Single sweep.** `prescale`=0, `dwell`=1, start/stop/step=10/30/10 → `phase_increment` 10,10,20,20,30,30. `busy` high for 6 cycles; `done` pulse on the 7th; three `step_strobe` pulses.
- **Triangle.** `dwell`=0, bounds 0/20/10 → 0,10,20,20,10,0,0,10…
- **Wrap guard (repeat).** 250/255/4 → 250,254,250,254…, never 2 (no 8-bit overflow).
- **Abort and conflicts.**
  - `abort` mid-sweep → IDLE next cycle, no `done`, increment held.
  - `start`+`abort` together in IDLE → stays IDLE.
  - `start` while busy → ignored.

Source files
------------

// File: rtl/nco_ctrl_pkg.sv
// Shared definitions for the NCO sweep controller and its prescaler.
package nco_ctrl_pkg;

   localparam int NCO_INC_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_UP   = 2'b01,
      ST_DOWN = 2'b10,
      ST_DONE = 2'b11
   } sweep_state_e;

   localparam logic [1:0] MODE_SINGLE   = 2'b00;
   localparam logic [1:0] MODE_REPEAT   = 2'b01;
   localparam logic [1:0] MODE_TRIANGLE = 2'b10;

   // A zero step would stall the sweep forever, so it is promoted to 1.
   function automatic logic [NCO_INC_W-1:0] eff_step(input logic [NCO_INC_W-1:0] step);
      logic [NCO_INC_W-1:0] res;
      if (step == {NCO_INC_W{1'b0}}) begin
         res = {{(NCO_INC_W-1){1'b0}}, 1'b1};
      end else begin
         res = step;
      end
      return res;
   endfunction

endpackage

// File: rtl/nco_prescaler.sv
// Free-running sample-rate prescaler: clk_en pulses once every prescale+1 clocks.
module nco_prescaler #(
   parameter int PRESCALE_W = 8
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  clk_en
);

   localparam logic [PRESCALE_W-1:0] CNT_ONE = PRESCALE_W'(1);

   logic [PRESCALE_W-1:0] cnt_r;
   logic                  clk_en_r;

   // Down-counter reloads the live prescale value at zero; the strobe follows one cycle later.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_r    <= {PRESCALE_W{1'b0}};
         clk_en_r <= 1'b0;
      end else if (cnt_r == {PRESCALE_W{1'b0}}) begin
         cnt_r    <= prescale;
         clk_en_r <= 1'b1;
      end else begin
         cnt_r    <= cnt_r - CNT_ONE;
         clk_en_r <= 1'b0;
      end
   end

   assign clk_en = clk_en_r;

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep sequencer driving the NCO phase increment and sample strobe.
module nco_sweep_ctrl
   import nco_ctrl_pkg::*;
#(
   parameter int PRESCALE_W = 8,
   parameter int DWELL_W    = 8
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [1:0]            mode,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic [NCO_INC_W-1:0]  f_start,
   input  logic [NCO_INC_W-1:0]  f_stop,
   input  logic [NCO_INC_W-1:0]  f_step,
   input  logic [DWELL_W-1:0]    dwell,
   output logic                  clk_en,
   output logic [NCO_INC_W-1:0]  phase_increment,
   output logic                  busy,
   output logic                  done,
   output logic                  step_strobe
);

   localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

   sweep_state_e           state_r, state_nxt_s;
   logic [1:0]             cfg_mode_r;
   logic [NCO_INC_W-1:0]   cfg_start_r, cfg_stop_r, cfg_step_r;
   logic [DWELL_W-1:0]     cfg_dwell_r;
   logic [DWELL_W-1:0]     dwell_cnt_r, dwell_nxt_s;
   logic [NCO_INC_W-1:0]   phase_inc_r, phase_nxt_s;
   logic                   step_strobe_r, strobe_s;
   logic                   busy_r, busy_s;
   logic                   done_r, done_s;
   logic                   load_cfg_s;
   logic [NCO_INC_W:0]     sum_s, diff_s;
   logic                   clk_en_s;

   nco_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
      .clock    (clock),
      .reset_n  (reset_n),
      .prescale (prescale),
      .clk_en   (clk_en_s)
   );

   // Next-state, dwell, increment and strobe decisions for the sweep FSM.
   always_comb begin
      state_nxt_s = state_r;
      dwell_nxt_s = dwell_cnt_r;
      phase_nxt_s = phase_inc_r;
      strobe_s    = 1'b0;
      load_cfg_s  = 1'b0;
      sum_s       = {1'b0, phase_inc_r} + {1'b0, cfg_step_r};
      diff_s      = {1'b0, phase_inc_r} - {1'b0, cfg_step_r};
      case (state_r)
         ST_IDLE: begin
            if (start && !abort) begin
               state_nxt_s = ST_UP;
               phase_nxt_s = f_start;
               dwell_nxt_s = dwell;
               strobe_s    = 1'b1;
               load_cfg_s  = 1'b1;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_UP: begin
            if (abort) begin
               state_nxt_s = ST_IDLE;
            end else if (!clk_en_s) begin
               state_nxt_s = ST_UP;
            end else if (dwell_cnt_r != {DWELL_W{1'b0}}) begin
               dwell_nxt_s = dwell_cnt_r - DWELL_ONE;
            end else begin
               dwell_nxt_s = cfg_dwell_r;
               if (sum_s <= {1'b0, cfg_stop_r}) begin
                  phase_nxt_s = sum_s[NCO_INC_W-1:0];
                  strobe_s    = 1'b1;
               end else begin
                  case (cfg_mode_r)
                     MODE_REPEAT: begin
                        phase_nxt_s = cfg_start_r;
                        strobe_s    = 1'b1;
                     end
                     MODE_TRIANGLE: state_nxt_s = ST_DOWN;
                     default:       state_nxt_s = ST_DONE;
                  endcase
               end
            end
         end
         ST_DOWN: begin
            if (abort) begin
               state_nxt_s = ST_IDLE;
            end else if (!clk_en_s) begin
               state_nxt_s = ST_DOWN;
            end else if (dwell_cnt_r != {DWELL_W{1'b0}}) begin
               dwell_nxt_s = dwell_cnt_r - DWELL_ONE;
            end else begin
               dwell_nxt_s = cfg_dwell_r;
               if (!diff_s[NCO_INC_W] && (diff_s[NCO_INC_W-1:0] >= cfg_start_r)) begin
                  phase_nxt_s = diff_s[NCO_INC_W-1:0];
                  strobe_s    = 1'b1;
               end else begin
                  state_nxt_s = ST_UP;
               end
            end
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
      busy_s = (state_nxt_s == ST_UP) || (state_nxt_s == ST_DOWN);
      done_s = (state_nxt_s == ST_DONE);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r       <= ST_IDLE;
         dwell_cnt_r   <= {DWELL_W{1'b0}};
         phase_inc_r   <= {NCO_INC_W{1'b0}};
         step_strobe_r <= 1'b0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         dwell_cnt_r   <= dwell_nxt_s;
         phase_inc_r   <= phase_nxt_s;
         step_strobe_r <= strobe_s;
         busy_r        <= busy_s;
         done_r        <= done_s;
      end
   end

   // Sweep configuration is captured only when a start is accepted.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cfg_mode_r  <= MODE_SINGLE;
         cfg_start_r <= {NCO_INC_W{1'b0}};
         cfg_stop_r  <= {NCO_INC_W{1'b0}};
         cfg_step_r  <= {{(NCO_INC_W-1){1'b0}}, 1'b1};
         cfg_dwell_r <= {DWELL_W{1'b0}};
      end else if (load_cfg_s) begin
         cfg_mode_r  <= mode;
         cfg_start_r <= f_start;
         cfg_stop_r  <= f_stop;
         cfg_step_r  <= eff_step(f_step);
         cfg_dwell_r <= dwell;
      end else begin
         cfg_mode_r  <= cfg_mode_r;
         cfg_start_r <= cfg_start_r;
         cfg_stop_r  <= cfg_stop_r;
         cfg_step_r  <= cfg_step_r;
         cfg_dwell_r <= cfg_dwell_r;
      end
   end

   assign clk_en          = clk_en_s;
   assign phase_increment = phase_inc_r;
   assign step_strobe     = step_strobe_r;
   assign busy            = busy_r;
   assign done            = done_r;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed self-checking bench for nco_sweep_ctrl.
module tb_nco_sweep_ctrl;

   logic       clock;
   logic       reset_n;
   logic       start;
   logic       abort;
   logic [1:0] mode;
   logic [7:0] prescale;
   logic [7:0] f_start, f_stop, f_step;
   logic [7:0] dwell;
   logic       clk_en;
   logic [7:0] phase_increment;
   logic       busy, done, step_strobe;

   int n_checks;
   int n_pass;
   int cnt;

   nco_sweep_ctrl #(.PRESCALE_W(8), .DWELL_W(8)) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .start           (start),
      .abort           (abort),
      .mode            (mode),
      .prescale        (prescale),
      .f_start         (f_start),
      .f_stop          (f_stop),
      .f_step          (f_step),
      .dwell           (dwell),
      .clk_en          (clk_en),
      .phase_increment (phase_increment),
      .busy            (busy),
      .done            (done),
      .step_strobe     (step_strobe)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_clk_en"}, {31'd0, clk_en}, 32'd0);
      check_val({tag, "_inc"}, {24'd0, phase_increment}, 32'd0);
      check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check_val({tag, "_done"}, {31'd0, done}, 32'd0);
      check_val({tag, "_strobe"}, {31'd0, step_strobe}, 32'd0);
   endtask

   initial begin
      logic [7:0] exp_single [6];
      logic       exp_sstb   [6];
      logic [7:0] exp_tri    [10];
      logic [7:0] exp_wrap   [6];
      exp_single = '{8'd10, 8'd10, 8'd20, 8'd20, 8'd30, 8'd30};
      exp_sstb   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      exp_tri    = '{8'd0, 8'd10, 8'd20, 8'd20, 8'd10, 8'd0, 8'd0, 8'd10, 8'd20, 8'd20};
      exp_wrap   = '{8'd250, 8'd254, 8'd250, 8'd254, 8'd250, 8'd254};

      n_checks = 0;
      n_pass   = 0;
      reset_n  = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      mode     = 2'b00;
      prescale = 8'd3;
      f_start  = 8'd0;
      f_stop   = 8'd0;
      f_step   = 8'd0;
      dwell    = 8'd0;

      // Reset state
      tick();
      tick();
      check_all_zero("reset");
      reset_n = 1'b1;

      // Prescaler: prescale=3 gives 1 pulse in 4 clocks
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (clk_en) cnt++;
      end
      check_val("presc3_count", cnt, 32'd10);

      // Prescaler: prescale=0 gives a constant strobe
      prescale = 8'd0;
      for (int i = 0; i < 5; i++) tick();
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (clk_en) cnt++;
      end
      check_val("presc0_count", cnt, 32'd20);

      // Single sweep 10/30/10, dwell 1; inputs scrambled mid-sweep must not matter
      mode = 2'b00; f_start = 8'd10; f_stop = 8'd30; f_step = 8'd10; dwell = 8'd1;
      pulse_start();
      f_stop = 8'd200; f_step = 8'd1; dwell = 8'd5; mode = 2'b01; f_start = 8'd3;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         check_val($sformatf("single_inc%0d", i), {24'd0, phase_increment}, {24'd0, exp_single[i]});
         check_val($sformatf("single_busy%0d", i), {31'd0, busy}, 32'd1);
         check_val($sformatf("single_stb%0d", i), {31'd0, step_strobe}, {31'd0, exp_sstb[i]});
         check_val($sformatf("single_done%0d", i), {31'd0, done}, 32'd0);
         if (step_strobe) cnt++;
         tick();
      end
      check_val("single_strobes", cnt, 32'd3);
      check_val("single_done_pulse", {31'd0, done}, 32'd1);
      check_val("single_busy_fall", {31'd0, busy}, 32'd0);
      tick();
      check_val("single_done_end", {31'd0, done}, 32'd0);
      check_val("single_inc_hold", {24'd0, phase_increment}, 32'd30);

      // Triangle 0/20/10, dwell 0, then abort
      mode = 2'b10; f_start = 8'd0; f_stop = 8'd20; f_step = 8'd10; dwell = 8'd0;
      pulse_start();
      for (int i = 0; i < 10; i++) begin
         check_val($sformatf("tri_inc%0d", i), {24'd0, phase_increment}, {24'd0, exp_tri[i]});
         check_val($sformatf("tri_busy%0d", i), {31'd0, busy}, 32'd1);
         if (i == 9) abort = 1'b1;
         tick();
      end
      abort = 1'b0;
      check_val("abort_busy", {31'd0, busy}, 32'd0);
      check_val("abort_inc_hold", {24'd0, phase_increment}, 32'd20);
      check_val("abort_strobe", {31'd0, step_strobe}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         check_val($sformatf("abort_no_done%0d", i), {31'd0, done}, 32'd0);
         tick();
      end

      // start and abort together in IDLE: start dropped
      f_start = 8'd77; mode = 2'b00;
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      check_val("conflict_busy", {31'd0, busy}, 32'd0);
      check_val("conflict_inc", {24'd0, phase_increment}, 32'd20);
      check_val("conflict_strobe", {31'd0, step_strobe}, 32'd0);

      // Repeat wrap guard 250/255/4, with an ignored start while busy
      mode = 2'b01; f_start = 8'd250; f_stop = 8'd255; f_step = 8'd4; dwell = 8'd0;
      pulse_start();
      for (int i = 0; i < 6; i++) begin
         check_val($sformatf("wrap_inc%0d", i), {24'd0, phase_increment}, {24'd0, exp_wrap[i]});
         check_val($sformatf("wrap_stb%0d", i), {31'd0, step_strobe}, 32'd1);
         if (i == 2) begin
            f_start = 8'd5;
            start   = 1'b1;
         end else begin
            start = 1'b0;
         end
         tick();
      end
      start = 1'b0;
      check_val("wrap_busy", {31'd0, busy}, 32'd1);

      // Asynchronous reset mid-sweep
      #3;
      reset_n = 1'b0;
      #2;
      check_all_zero("async_rst");
      reset_n = 1'b1;
      tick();
      check_val("post_rst_busy", {31'd0, busy}, 32'd0);
      check_val("post_rst_inc", {24'd0, phase_increment}, 32'd0);
      tick();
      check_val("post_rst_clk_en", {31'd0, clk_en}, 32'd1);

      // f_step=0 treated as 1: 5,6,7 then done
      mode = 2'b00; f_start = 8'd5; f_stop = 8'd7; f_step = 8'd0; dwell = 8'd0;
      pulse_start();
      for (int i = 0; i < 3; i++) begin
         check_val($sformatf("step0_inc%0d", i), {24'd0, phase_increment}, 32'd5 + i);
         tick();
      end
      check_val("step0_done", {31'd0, done}, 32'd1);
      tick();

      // Degenerate single: f_start >= f_stop gives one dwell then done
      mode = 2'b11; f_start = 8'd40; f_stop = 8'd30; f_step = 8'd10; dwell = 8'd0;
      pulse_start();
      check_val("degen_inc", {24'd0, phase_increment}, 32'd40);
      check_val("degen_busy", {31'd0, busy}, 32'd1);
      tick();
      check_val("degen_done", {31'd0, done}, 32'd1);
      check_val("degen_inc_hold", {24'd0, phase_increment}, 32'd40);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
